// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
//
// Purpose:
//   One pipelined AES inverse-cipher round:
//     InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
//   InvMixColumns is bypassed for beats flagged as the final inverse round.
//   Two register stages with a valid/ready handshake on both sides and full
//   backpressure; 2-cycle latency, one beat per cycle throughput.
//
// Optional feature:
//   AES_INV_ROUND_TAG_EN - when defined, adds in_tag/out_tag (TAG_W bits) that
//   travel with each beat through both stages.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts an input beat this cycle
//   in_last    final inverse round: skip InvMixColumns
//   key        round key, sampled together with state
//   state      input state, element [r][c] = row r, column c
//   in_tag     sideband tag of the input beat (AES_INV_ROUND_TAG_EN only)
//   out_tag    sideband tag of the output beat (AES_INV_ROUND_TAG_EN only)
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   new_state  round result, straight from the stage-2 register
// -----------------------------------------------------------------------------
module aes_inv_round #(
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [3:0][3:0][7:0]  key,
    input  logic [3:0][3:0][7:0]  state,
`ifdef AES_INV_ROUND_TAG_EN
    input  logic [TAG_W-1:0]      in_tag,
    output logic [TAG_W-1:0]      out_tag,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][3:0][7:0]  new_state
);

    typedef logic [3:0][3:0][7:0] block_t;

    if (TAG_W < 1) begin : g_tag_w_check
        $error("aes_inv_round: TAG_W must be at least 1");
    end

    // FIPS-197 inverse S-box, indexed by the byte value.
    // NOTE: this table is a constant ROM, so it has no reset and no clock;
    // only the pipeline registers below are reset.
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns: each column multiplied by the circulant {0e,0b,0d,09}.
    // The odd coefficients are built from b, 2b, 4b and 8b.
    function automatic block_t inv_mix_columns(input block_t a);
        block_t     m;
        logic [7:0] x1, x2, x4, x8;
        logic [3:0][7:0] m9, mb, md, me;
        m = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                x1    = a[r][c];
                x2    = xtime(x1);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ x1;
                mb[r] = x8 ^ x2 ^ x1;
                md[r] = x8 ^ x4 ^ x1;
                me[r] = x8 ^ x4 ^ x2;
            end
            m[0][c] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            m[1][c] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            m[2][c] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            m[3][c] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return m;
    endfunction

    // Handshake: a stage may load when it is empty or its contents move on.
    logic adv1;
    logic adv2;

    logic   s1_v;
    block_t s1_sb;
    block_t s1_key;
    logic   s1_last;

    logic   s2_v;
    block_t s2_res;

    block_t sb_d;
    block_t ak;
    block_t res_d;

    assign adv2     = !s2_v || out_ready;
    assign adv1     = !s1_v || adv2;
    assign in_ready = adv1;

    // Stage-1 input: InvShiftRows then InvSubBytes on every byte.
    // InvShiftRows rotates row r right by r, so column c picks column c-r.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // through the block leaves it unassigned and infers a latch.
        sb_d = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sb_d[r][c] = INV_SBOX[state[r][2'(c - r)]];
            end
        end
    end

    // Stage-2 input: AddRoundKey, then InvMixColumns unless this is the last
    // inverse round.
    always_comb begin
        ak    = s1_sb ^ s1_key;
        res_d = ak;
        if (!s1_last) begin
            res_d = inv_mix_columns(ak);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sb   <= '0;
            s1_key  <= '0;
            s1_last <= 1'b0;
            s2_v    <= 1'b0;
            s2_res  <= '0;
        end else begin
            // NOTE: non-blocking assignments so stage 2 captures the stage-1
            // value from before this edge, not the one loaded in the same edge.
            if (adv2) begin
                s2_v   <= s1_v;
                s2_res <= res_d;
            end
            if (adv1) begin
                s1_v    <= in_valid;
                s1_sb   <= sb_d;
                s1_key  <= key;
                s1_last <= in_last;
            end
        end
    end

`ifdef AES_INV_ROUND_TAG_EN
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;

    // Tag follows the same advance enables as the data it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag <= '0;
            s2_tag <= '0;
        end else begin
            if (adv2) begin
                s2_tag <= s1_tag;
            end
            if (adv1) begin
                s1_tag <= in_tag;
            end
        end
    end

    assign out_tag = s2_tag;
`else
    // No sideband: the tag ports and their registers do not exist.
`endif

    assign out_valid = s2_v;
    assign new_state = s2_res;

endmodule

// File: tb/tb_aes_inv_round.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_round
//
// Self-checking bench for aes_inv_round. Directed vectors with fixed expected
// results, a backpressure stream, a mid-flight reset and a randomized stream
// checked against a software inverse-round model. The model derives its
// inverse S-box from the GF(2^8) inverse and the inverse affine map, not from
// a table. Define AES_INV_ROUND_TAG_EN for both files to exercise the tag.
// -----------------------------------------------------------------------------
module tb_aes_inv_round;

    typedef logic [3:0][3:0][7:0] blk_t;
    typedef struct {
        blk_t       res;
        logic [7:0] tag;
    } exp_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic in_valid  = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b0;
    blk_t key       = '0;
    blk_t state     = '0;
    logic in_ready;
    logic out_valid;
    blk_t new_state;
`ifdef AES_INV_ROUND_TAG_EN
    logic [7:0] in_tag = '0;
    logic [7:0] out_tag;
`endif

    aes_inv_round #(.TAG_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .key       (key),
        .state     (state),
`ifdef AES_INV_ROUND_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .new_state (new_state)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_emit   = 0;
    logic last_acc = 1'b0;
    logic stalled_prev = 1'b0;
    blk_t held_state;
    exp_t q[$];
    logic [7:0] isbox [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    task automatic build_isbox();
        logic [7:0] x;
        logic [7:0] inv;
        for (int y = 0; y < 256; y++) begin
            logic [7:0] yb;
            yb  = 8'(y);
            x   = rotl(yb, 1) ^ rotl(yb, 3) ^ rotl(yb, 6) ^ 8'h05;
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
            end
            isbox[y] = inv;
        end
    endtask

    function automatic blk_t ref_round(input blk_t st, input blk_t k, input logic last);
        blk_t a;
        blk_t o;
        logic [7:0] coef [4];
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = isbox[st[r][(c - r + 4) % 4]] ^ k[r][c];
        if (last) return a;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o[r][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    o[r][c] = o[r][c] ^ gmul(coef[(j - r + 4) % 4], a[j][c]);
            end
        return o;
    endfunction

    function automatic blk_t rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: inputs were driven at the preceding negedge.
    task automatic cycle();
        exp_t e;
        logic stalled_now;
        #1;
        if (stalled_prev) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_hold", new_state, held_state);
        end
        stalled_now = out_valid && !out_ready;
        held_state  = new_state;
        if (out_valid && out_ready) begin
            n_emit++;
            chk("beat_expected", (q.size() != 0), 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("data", new_state, e.res);
`ifdef AES_INV_ROUND_TAG_EN
                chk("tag", out_tag, e.tag);
`endif
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            e.res = ref_round(state, key, in_last);
`ifdef AES_INV_ROUND_TAG_EN
            e.tag = in_tag;
`else
            e.tag = 8'h00;
`endif
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        stalled_prev = stalled_now;
    endtask

    task automatic send_one(input string name, input blk_t st, input blk_t k,
                            input logic last, input blk_t exp);
        state = st; key = k; in_last = last; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk({name, "_accept"}, last_acc, 1'b1);
        in_valid = 1'b0;
        chk({name, "_lat1"}, out_valid, 1'b0);
        cycle();
        chk({name, "_lat2"}, out_valid, 1'b1);
        chk(name, new_state, exp);
        cycle();
    endtask

    initial begin
        int base;
        int idx;
        int budget;
        int presented;
        blk_t bp_st [6];

        build_isbox();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_new_state", new_state, '0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef AES_INV_ROUND_TAG_EN
        chk("rst_out_tag", out_tag, 8'h00);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        send_one("zero_last", '0, '0, 1'b1, {16{8'h52}});
        send_one("s63_k00", {16{8'h63}}, '0, 1'b0, '0);
        send_one("s63_kff", {16{8'h63}}, {16{8'hff}}, 1'b0, {16{8'hff}});
        send_one("s00_k52", '0, {16{8'h52}}, 1'b0, '0);

        // Back-to-back beats, alternating last, distinct keys.
        base = n_emit;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            state = rand_blk(); key = {16{8'(i * 17 + 1)}}; in_last = i[0];
            in_valid = 1'b1;
`ifdef AES_INV_ROUND_TAG_EN
            in_tag = 8'(8'hA0 + i);
`endif
            cycle();
            chk("b2b_accept", last_acc, 1'b1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("b2b_count", n_emit - base, 8);

        // Backpressure: 6 beats, out_ready low for 5 cycles.
        base = n_emit;
        for (int i = 0; i < 6; i++) bp_st[i] = rand_blk();
        idx = 0;
        out_ready = 1'b0;
        key = rand_blk(); in_last = 1'b0;
        state = bp_st[0]; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (last_acc) begin
                idx++;
                state = bp_st[idx];
`ifdef AES_INV_ROUND_TAG_EN
                in_tag = 8'(8'hB0 + idx);
`endif
            end
        end
        #1;
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        budget = 0;
        while (idx < 6 && budget < 50) begin
            cycle();
            budget++;
            if (last_acc) begin
                idx++;
                if (idx < 6) state = bp_st[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        budget = 0;
        while (q.size() != 0 && budget < 10) begin
            cycle();
            budget++;
        end
        chk("bp_delivered", n_emit - base, 6);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        state = rand_blk(); key = rand_blk(); in_last = 1'b0; in_valid = 1'b1;
        cycle();
        state = rand_blk();
        cycle();
        in_valid = 1'b0;
        chk("rst_pre_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_state", new_state, '0);
        q.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_no_stale", out_valid, 1'b0);
        end
        send_one("post_rst", '0, '0, 1'b1, {16{8'h52}});

        // Randomized stream with random backpressure.
        base = n_emit;
        budget = 0;
        presented = 0;
        while ((n_emit - base) < 1000 && budget < 20000) begin
            out_ready = ($urandom_range(9) < 7);
            if (!in_valid && presented < 1000 && $urandom_range(3) != 0) begin
                state = rand_blk(); key = rand_blk(); in_last = 1'($urandom_range(1));
`ifdef AES_INV_ROUND_TAG_EN
                in_tag = 8'(presented);
`endif
                in_valid = 1'b1;
                presented++;
            end
            cycle();
            if (last_acc) in_valid = 1'b0;
            budget++;
        end
        chk("rand_count", n_emit - base, 1000);
        chk("rand_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
